bcd_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `binaryToBCD` converter among `N_REQ` requesters, such as per-core cycle/result counters feeding the seven-segment display path. It grants one requester at a time, issues a single start to the converter, and waits for `done`. It then captures the 8-digit BCD result, tags it with the owner index, and acknowledges the requester. A watchdog aborts conversions that never complete.

---
 rtl/bcd_conv_arbiter.sv | 133 +++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one binaryToBCD converter among N_REQ requesters.
// Grants one requester, issues a single start, waits for done (with watchdog), then captures and acks.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [26*N_REQ-1:0] value,
  output logic [N_REQ-1:0]    ack,
  output logic                err,
  output logic                busy,
  output logic [31:0]         bcd_out,
  output logic [2:0]          bcd_owner,
  output logic                conv_start,
  output logic [25:0]         conv_value,
  input  logic                conv_ready,
  input  logic                conv_done,
  input  logic [31:0]         conv_digits,
  output logic [1:0]          dbg_state
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t           r_state;
  logic [2:0]       r_grant;
  logic [2:0]       r_last_grant;
  logic [WDW-1:0]   r_wd;
  logic [N_REQ-1:0] r_ack;
  logic             r_err;
  logic             r_start;
  logic [25:0]      r_value;
  logic [31:0]      r_bcd;
  logic [2:0]       r_owner;

  logic [7:0]       w_req_ext;
  logic [25:0]      w_ops [8];
  logic             w_found;
  logic [2:0]       w_pick;

  assign w_req_ext = 8'(req);

  for (genvar g = 0; g < 8; g++) begin : g_ops
    if (g < N_REQ) begin : g_on
      assign w_ops[g] = value[26*g +: 26];
    end else begin : g_off
      assign w_ops[g] = '0;
    end
  end

  // First pending requester strictly after last_grant, wrapping modulo N_REQ.
  always_comb begin
    int t;
    t       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int o = 1; o <= N_REQ; o++) begin
      t = int'(r_last_grant) + o;
      if (t >= N_REQ) t = t - N_REQ;
      if (!w_found && w_req_ext[3'(t)]) begin
        w_found = 1'b1;
        w_pick  = 3'(t);
      end
    end
  end

  // Handshakes: a requester holds req until its one-cycle ack; the converter accepts a
  // one-cycle conv_start only while conv_ready is high and answers with a one-cycle conv_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= 3'(N_REQ - 1);
      r_wd         <= '0;
      r_ack        <= '0;
      r_err        <= 1'b0;
      r_start      <= 1'b0;
      r_value      <= '0;
      r_bcd        <= '0;
      r_owner      <= '0;
    end else begin
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (conv_ready && w_found) begin
            r_grant <= w_pick;
            r_value <= w_ops[w_pick];
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done) begin
            r_bcd   <= conv_digits;
            r_owner <= r_grant;
            for (int i = 0; i < N_REQ; i++) r_ack[i] <= (r_grant == 3'(i));
            r_state <= S_CAPTURE;
          end else if (r_wd == WDW'(TIMEOUT - 1)) begin
            // Abort: the requester loses its turn so a dead operand cannot starve others.
            r_err        <= 1'b1;
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack        = r_ack;
  assign err        = r_err;
  assign busy       = (r_state != S_IDLE);
  assign bcd_out    = r_bcd;
  assign bcd_owner  = r_owner;
  assign conv_start = r_start;
  assign conv_value = r_value;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: behavioural converter, round-robin reference model and
// per-scenario tasks with inline comparisons.
module tb_bcd_conv_arbiter;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 56;
  localparam int MAXV    = 67108863;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [26*N_REQ-1:0] value;
  logic [N_REQ-1:0]    ack;
  logic                err;
  logic                busy;
  logic [31:0]         bcd_out;
  logic [2:0]          bcd_owner;
  logic                conv_start;
  logic [25:0]         conv_value;
  logic                conv_ready;
  logic                conv_done = 1'b0;
  logic [31:0]         conv_digits = '0;
  logic [1:0]          dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          own_q[$];

  int          last_g;
  logic [31:0] exp_bcd_last;
  int          exp_own_last;
  logic [25:0] vals [N_REQ];

  bcd_conv_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .value(value), .ack(ack), .err(err), .busy(busy),
    .bcd_out(bcd_out), .bcd_owner(bcd_owner), .conv_start(conv_start), .conv_value(conv_value),
    .conv_ready(conv_ready), .conv_done(conv_done), .conv_digits(conv_digits), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input logic [25:0] v);
    logic [31:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int next_owner(input logic [N_REQ-1:0] pend, input int last);
    for (int o = 1; o <= N_REQ; o++) begin
      if (pend[(last + o) % N_REQ]) return (last + o) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int o);
    logic [N_REQ-1:0] r;
    r = '0;
    r[o] = 1'b1;
    return r;
  endfunction

  // Behavioural converter: LAT cycles from accepted start to a one-cycle done.
  int   cv_cnt = 0;
  logic [25:0] cv_op = '0;
  bit   stuck = 1'b0;
  bit   hold_nr = 1'b0;
  logic model_ready = 1'b1;
  assign conv_ready = model_ready && !hold_nr;

  always @(negedge clk) begin
    conv_done = 1'b0;
    if (!rst) begin
      cv_cnt = 0;
    end else if (cv_cnt > 0) begin
      cv_cnt--;
      if (cv_cnt == 0) begin
        conv_done   = 1'b1;
        conv_digits = to_bcd(cv_op);
      end
    end else if (conv_start && !stuck) begin
      cv_op  = conv_value;
      cv_cnt = LAT;
    end
    model_ready = (cv_cnt == 0);
  end

  // driver tasks
  task automatic set_val(input int i, input logic [25:0] v);
    vals[i] = v;
    value[26*i +: 26] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output logic [N_REQ-1:0] a, output int gap,
                          output int lat, output int n_start, output logic [25:0] cv,
                          output bit saw_err, output bit to);
    int st_at;
    a = '0; gap = -1; lat = -1; n_start = 0; cv = '0; saw_err = 1'b0; to = 1'b1; st_at = -1;
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (conv_start) begin
        n_start++;
        if (gap < 0) begin
          gap = t; cv = conv_value; st_at = t;
        end
      end
      if (|ack || err) begin
        a = ack; saw_err = err; to = 1'b0;
        lat = (st_at < 0) ? -1 : t - st_at;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; value = '0;
    for (int i = 0; i < N_REQ; i++) vals[i] = '0;
    idle(3);
    n_cmp++; if (ack !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_ack_err: got ack=%b err=%b expected 0", ack, err); end
    n_cmp++; if (busy !== 1'b0 || conv_start !== 1'b0) begin n_bad++; $display("FAIL reset_busy_start: got busy=%b start=%b expected 0", busy, conv_start); end
    n_cmp++; if (conv_value !== '0 || bcd_out !== '0 || bcd_owner !== '0) begin n_bad++; $display("FAIL reset_data: got cv=%0h bcd=%0h own=%0d expected 0", conv_value, bcd_out, bcd_owner); end
    rst = 1'b1;
    last_g = N_REQ - 1; exp_bcd_last = '0; exp_own_last = 0;
    idle(2);
  endtask

  task automatic test_three();
    int ords [3];
    logic [31:0] exps [3];
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    ords = '{0, 1, 2};
    exps = '{32'h00043210, 32'h00000007, 32'h67108863};
    set_val(0, 26'd43210); set_val(1, 26'd7); set_val(2, 26'(MAXV)); set_val(3, 26'd0);
    req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      wait_ack(200, a, gap, lat, ns, cv, se, to);
      n_cmp++; if (to || a !== onehot(ords[k])) begin n_bad++; $display("FAIL three_ack%0d: got %b (timeout=%0d) expected %b", k, a, to, onehot(ords[k])); end
      n_cmp++; if (bcd_out !== exps[k] || bcd_owner !== 3'(ords[k])) begin n_bad++; $display("FAIL three_bcd%0d: got %h/%0d expected %h/%0d", k, bcd_out, bcd_owner, exps[k], ords[k]); end
      n_cmp++; if (gap !== ((k == 0) ? 1 : 2)) begin n_bad++; $display("FAIL three_gap%0d: got %0d expected %0d", k, gap, (k == 0) ? 1 : 2); end
      req[ords[k]] = 1'b0;
      last_g = ords[k]; exp_bcd_last = exps[k]; exp_own_last = ords[k];
      if (to) break;
    end
    req = '0;
    idle(2);
  endtask

  task automatic test_rr();
    int ords [4];
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    ords = '{3, 0, 3, 0};
    for (int i = 0; i < N_REQ; i++) set_val(i, 26'($urandom_range(0, MAXV)));
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ack(200, a, gap, lat, ns, cv, se, to);
      n_cmp++; if (to || a !== onehot(ords[k])) begin n_bad++; $display("FAIL rr_ack%0d: got %b (timeout=%0d) expected %b", k, a, to, onehot(ords[k])); end
      n_cmp++; if (bcd_out !== to_bcd(vals[ords[k]]) || bcd_owner !== 3'(ords[k])) begin n_bad++; $display("FAIL rr_bcd%0d: got %h/%0d expected %h/%0d", k, bcd_out, bcd_owner, to_bcd(vals[ords[k]]), ords[k]); end
      last_g = ords[k]; exp_bcd_last = to_bcd(vals[ords[k]]); exp_own_last = ords[k];
      // requester 0 stays high after its first ack while 3 re-requests
      if (k == 1) req[3] = 1'b1;
      else req[ords[k]] = 1'b0;
      if (to) break;
    end
    req = '0;
    idle(2);
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    set_val(0, 26'd162);
    req = 4'b0001;
    wait_ack(200, a, gap, lat, ns, cv, se, to);
    req = '0;
    n_cmp++; if (to || a !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b (timeout=%0d) expected 0001", a, to); end
    n_cmp++; if (ns !== 1 || cv !== 26'd162) begin n_bad++; $display("FAIL single_start: got starts=%0d cv=%0d expected 1/162", ns, cv); end
    n_cmp++; if (bcd_out !== 32'h00000162 || bcd_owner !== 3'd0) begin n_bad++; $display("FAIL single_bcd: got %h/%0d expected 00000162/0", bcd_out, bcd_owner); end
    n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT + 1); end
    @(negedge clk);
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL single_ack_pulse: got %b expected 0000", ack); end
    last_g = 0; exp_bcd_last = 32'h00000162; exp_own_last = 0;
    idle(2);
  endtask

  task automatic test_stuck();
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    stuck = 1'b1;
    set_val(1, 26'($urandom_range(0, MAXV)));
    req = 4'b0010;
    wait_ack(200, a, gap, lat, ns, cv, se, to);
    req = '0;
    n_cmp++; if (to || !se || a !== '0) begin n_bad++; $display("FAIL stuck_err: got err=%0d ack=%b timeout=%0d expected err=1 ack=0000", se, a, to); end
    // one ISSUE cycle plus TIMEOUT cycles in WAIT
    n_cmp++; if (lat !== TIMEOUT + 1) begin n_bad++; $display("FAIL stuck_time: got %0d expected %0d", lat, TIMEOUT + 1); end
    n_cmp++; if (bcd_out !== exp_bcd_last || bcd_owner !== 3'(exp_own_last)) begin n_bad++; $display("FAIL stuck_bcd_kept: got %h/%0d expected %h/%0d", bcd_out, bcd_owner, exp_bcd_last, exp_own_last); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b0 || conv_start !== 1'b0) begin n_bad++; $display("FAIL stuck_idle: got err=%b busy=%b start=%b expected 0/0/0", err, busy, conv_start); end
    stuck = 1'b0;
    last_g = 1;
    idle(2);
  endtask

  task automatic test_ready_hold();
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    int starts;
    logic [25:0] v1;
    hold_nr = 1'b1;
    v1 = 26'($urandom_range(0, MAXV));
    set_val(1, v1);
    req = 4'b0010;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (conv_start || busy) starts++;
    end
    n_cmp++; if (starts !== 0) begin n_bad++; $display("FAIL hold_no_start: got %0d active cycles expected 0", starts); end
    hold_nr = 1'b0;
    @(negedge clk);
    n_cmp++; if (conv_start !== 1'b1 || conv_value !== v1) begin n_bad++; $display("FAIL hold_release_grant: got start=%b cv=%0d expected 1/%0d", conv_start, conv_value, v1); end
    // operand change and request drop after grant must not disturb the conversion
    set_val(1, 26'($urandom_range(0, MAXV)));
    req = '0;
    wait_ack(200, a, gap, lat, ns, cv, se, to);
    n_cmp++; if (to || a !== 4'b0010 || bcd_out !== to_bcd(v1)) begin n_bad++; $display("FAIL hold_result: got %b/%h expected 0010/%h", a, bcd_out, to_bcd(v1)); end
    last_g = 1; exp_bcd_last = to_bcd(v1); exp_own_last = 1;
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    bit seen; bit bad; int first;
    for (int i = 0; i < N_REQ; i++) set_val(i, 26'($urandom_range(0, MAXV)));
    req = 4'b0101;
    first = next_owner(4'b0101, last_g);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = conv_start;
    end
    n_cmp++; if (!seen || conv_value !== vals[first]) begin n_bad++; $display("FAIL rstmid_pre_grant: got seen=%0d cv=%0d expected 1/%0d", seen, conv_value, vals[first]); end
    idle(5);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if ({ack, err, busy, conv_start, conv_value, bcd_out, bcd_owner} !== '0) begin n_bad++; $display("FAIL rstmid_async_clear: got ack=%b err=%b busy=%b st=%b cv=%0h bcd=%0h own=%0d expected 0", ack, err, busy, conv_start, conv_value, bcd_out, bcd_owner); end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (|ack || err || busy) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: got activity=%0d expected 0", bad); end
    rst = 1'b1;
    last_g = N_REQ - 1; exp_bcd_last = '0; exp_own_last = 0;
    wait_ack(200, a, gap, lat, ns, cv, se, to);
    n_cmp++; if (to || a !== 4'b0001 || cv !== vals[0] || bcd_out !== to_bcd(vals[0])) begin n_bad++; $display("FAIL rstmid_first: got %b cv=%0d bcd=%h expected 0001/%0d/%h", a, cv, bcd_out, vals[0], to_bcd(vals[0])); end
    req[0] = 1'b0;
    wait_ack(200, a, gap, lat, ns, cv, se, to);
    n_cmp++; if (to || a !== 4'b0100 || bcd_out !== to_bcd(vals[2])) begin n_bad++; $display("FAIL rstmid_second: got %b bcd=%h expected 0100/%h", a, bcd_out, to_bcd(vals[2])); end
    req = '0;
    last_g = 2; exp_bcd_last = to_bcd(vals[2]); exp_own_last = 2;
    idle(2);
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] a; int gap, lat, ns; logic [25:0] cv; bit se, to;
    logic [N_REQ-1:0] mask, pend;
    int lg, o, k;
    logic [31:0] e;
    for (int r = 0; r < 6; r++) begin
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) set_val(i, 26'($urandom_range(0, MAXV)));
      pend = mask; lg = last_g;
      while (pend != '0) begin
        o = next_owner(pend, lg);
        own_q.push_back(o);
        exp_q.push_back(to_bcd(vals[o]));
        pend[o] = 1'b0;
        lg = o;
      end
      req = mask;
      k = 0;
      while (own_q.size() > 0) begin
        o = own_q.pop_front();
        e = exp_q.pop_front();
        wait_ack(200, a, gap, lat, ns, cv, se, to);
        n_cmp++; if (to || a !== onehot(o) || bcd_out !== e || bcd_owner !== 3'(o)) begin n_bad++; $display("FAIL rand_r%0d_k%0d: got %b %h/%0d expected %b %h/%0d", r, k, a, bcd_out, bcd_owner, onehot(o), e, o); end
        n_cmp++; if (gap !== ((k == 0) ? 1 : 2)) begin n_bad++; $display("FAIL rand_gap_r%0d_k%0d: got %0d expected %0d", r, k, gap, (k == 0) ? 1 : 2); end
        req[o] = 1'b0;
        last_g = o; exp_bcd_last = e; exp_own_last = o;
        k++;
        if (to) begin
          own_q.delete(); exp_q.delete();
        end
      end
      req = '0;
      idle(2);
    end
  endtask

  initial begin
    test_reset();
    test_three();
    test_rr();
    test_single();
    test_stuck();
    test_ready_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
